// File: rtl/prio_enc_pkg.sv
// -----------------------------------------------------------------------------
// prio_enc_pkg
//   Shared definitions for the registered priority / round-robin encoder.
//   - MODE_FIXED / MODE_RR : encodings of the rr_mode input
//   - MAX_N                : widest request vector the encoder supports
//   - popcount_gt1()       : true when more than one bit of a vector is set
// -----------------------------------------------------------------------------
package prio_enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  localparam int MAX_N = 64;

  // Clearing the lowest set bit leaves something behind only if at least two
  // bits were set, so no adder tree is needed.
  function automatic logic popcount_gt1(input logic [MAX_N-1:0] v);
    return (v & (v - 64'd1)) != '0;
  endfunction

endpackage

// File: rtl/prio_rr_search.sv
// -----------------------------------------------------------------------------
// prio_rr_search
//   Combinational downward priority search with wrap-around.
//   The search starts at index 'start', moves toward 0, then wraps to N-1.
//   The first set request bit encountered is the winner.
//
// Ports:
//   req    [N-1:0] in   request vector, bit i requests index i
//   start  [W-1:0] in   first index examined (must be < N)
//   winner [W-1:0] out  selected index (0 when nothing is requested)
//   found          out  at least one request bit is set
// -----------------------------------------------------------------------------
module prio_rr_search
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] winner,
  output logic         found
);

  logic [W-1:0] lo_win;
  logic [W-1:0] hi_win;
  logic         lo_found;

  // The downward search with wrap reduces to: the highest set bit at or
  // below 'start' if one exists, otherwise the highest set bit overall
  // (which then necessarily sits above 'start', i.e. after the wrap).
  always_comb begin
    lo_win   = '0;
    hi_win   = '0;
    lo_found = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        found  = 1'b1;
        hi_win = W'(i);
        if (i <= int'(start)) begin
          lo_found = 1'b1;
          lo_win   = W'(i);
        end
      end
    end
    winner = lo_found ? lo_win : hi_win;
  end

endmodule

// File: rtl/prio_enc_rr_reg.sv
// -----------------------------------------------------------------------------
// prio_enc_rr_reg
//   Registered N-input priority encoder with fixed (MSB highest) or
//   round-robin arbitration and a one-deep valid/ready output register.
//
// Ports:
//   clk               in   rising-edge clock
//   rst               in   synchronous active-high reset
//   en                in   encode enable; no capture when low
//   rr_mode           in   0 = fixed priority, 1 = round-robin
//   req       [N-1:0] in   request vector
//   out_ready         in   consumer accepts the current result
//   out_valid         out  out_idx holds a valid result
//   out_idx   [W-1:0] out  winning index
//   out_multi         out  more than one request was set at capture
//   out_grant [N-1:0] out  one-hot of out_idx (only with PRIO_ENC_ONEHOT_EN)
//
// Build option:
//   PRIO_ENC_ONEHOT_EN  adds the registered one-hot out_grant port.
// -----------------------------------------------------------------------------
module prio_enc_rr_reg
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         rr_mode,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_multi
`ifdef PRIO_ENC_ONEHOT_EN
  ,
  output logic [N-1:0] out_grant
`endif
);

  logic [W-1:0] ptr;
  logic [W-1:0] start_rr;
  logic [W-1:0] start;
  logic [W-1:0] winner;
  logic         found;
  logic         multi;
  logic         cap;

  logic         vld_p1;
  logic [W-1:0] idx_p1;
  logic         multi_p1;

  // ptr is the last grant and gets lowest priority, so the search starts one
  // below it. Wrapping targets N-1 explicitly so non-power-of-two N never
  // yields an index outside the request vector.
  assign start_rr = (ptr == '0) ? W'(N - 1) : ptr - W'(1);
  assign start    = (rr_mode == MODE_RR) ? start_rr : W'(N - 1);

  prio_rr_search #(.N(N)) u_search (
    .req    (req),
    .start  (start),
    .winner (winner),
    .found  (found)
  );

  assign multi = popcount_gt1(MAX_N'(req));

  // A new result may load when the register is empty or being drained.
  assign cap = en && found && (!vld_p1 || out_ready);

  // ---- stage p1: output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      idx_p1   <= '0;
      multi_p1 <= 1'b0;
      ptr      <= '0;
    end else if (cap) begin
      vld_p1   <= 1'b1;
      idx_p1   <= winner;
      multi_p1 <= multi;
      ptr      <= winner;
    end else if (out_ready) begin
      vld_p1   <= 1'b0;
    end
  end

`ifdef PRIO_ENC_ONEHOT_EN
  logic [N-1:0] grant_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_p1 <= '0;
    end else if (cap) begin
      grant_p1 <= N'(1) << winner;
    end
  end

  assign out_grant = grant_p1;
`endif

  assign out_valid = vld_p1;
  assign out_idx   = idx_p1;
  assign out_multi = multi_p1;

endmodule

// File: tb/tb_prio_enc_rr_reg.sv
// -----------------------------------------------------------------------------
// tb_prio_enc_rr_reg
//   Self-checking bench for prio_enc_rr_reg. Two instances: N=8 and N=5
//   (non-power-of-two wrap). Directed vector tables followed by random
//   stimulus checked against a behavioural arbitration model.
// -----------------------------------------------------------------------------
module tb_prio_enc_rr_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // N=8 instance
  logic       rst8, en8, rr8, rdy8;
  logic [7:0] req8;
  logic       v8, m8;
  logic [2:0] idx8;
  // N=5 instance
  logic       rst5, en5, rr5, rdy5;
  logic [4:0] req5;
  logic       v5, m5;
  logic [2:0] idx5;
`ifdef PRIO_ENC_ONEHOT_EN
  logic [7:0] g8;
  logic [4:0] g5;
`endif

  prio_enc_rr_reg #(.N(8)) dut8 (
    .clk(clk), .rst(rst8), .en(en8), .rr_mode(rr8), .req(req8),
    .out_ready(rdy8), .out_valid(v8), .out_idx(idx8), .out_multi(m8)
`ifdef PRIO_ENC_ONEHOT_EN
    , .out_grant(g8)
`endif
  );

  prio_enc_rr_reg #(.N(5)) dut5 (
    .clk(clk), .rst(rst5), .en(en5), .rr_mode(rr5), .req(req5),
    .out_ready(rdy5), .out_valid(v5), .out_idx(idx5), .out_multi(m5)
`ifdef PRIO_ENC_ONEHOT_EN
    , .out_grant(g5)
`endif
  );

  typedef struct {
    bit         rst;
    bit         en;
    bit         rr;
    logic [7:0] req;
    bit         rdy;
    bit         ev;
    int         eidx;
    bit         em;
  } vec_t;

  typedef struct {
    bit v;
    int idx;
    bit multi;
    int ptr;
  } mstate_t;

  vec_t vecs8[$];
  vec_t vecs5[$];

  function automatic vec_t mk(bit r, bit e, bit rr, logic [7:0] q, bit y,
                              bit ev, int ei, bit em);
    vec_t t;
    t.rst = r; t.en = e; t.rr = rr; t.req = q; t.rdy = y;
    t.ev = ev; t.eidx = ei; t.em = em;
    return t;
  endfunction

  task automatic chk(input string nm, input int step,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=%0d required=%0d", nm, step, act, exp);
    end
  endtask

  // Reference model: walks the candidate indices in priority order.
  function automatic mstate_t mnext(mstate_t s, int n, bit r, bit e, bit rr,
                                    logic [63:0] q, bit y);
    mstate_t t;
    bit      any;
    int      w;
    int      c;
    t   = s;
    any = 1'b0;
    w   = 0;
    if (r) begin
      t.v = 1'b0; t.idx = 0; t.multi = 1'b0; t.ptr = 0;
      return t;
    end
    if (e && (!s.v || y)) begin
      if (rr) begin
        for (int k = 1; k <= n; k++) begin
          c = ((s.ptr - k) % n + n) % n;
          if (!any && q[c]) begin any = 1'b1; w = c; end
        end
      end else begin
        for (int i = n - 1; i >= 0; i--) begin
          if (!any && q[i]) begin any = 1'b1; w = i; end
        end
      end
    end
    if (any) begin
      t.v = 1'b1; t.idx = w; t.multi = ($countones(q) > 1); t.ptr = w;
    end else if (s.v && y) begin
      t.v = 1'b0;
    end
    return t;
  endfunction

  mstate_t ms8, ms5, nx8, nx5;

  initial begin
    total = 0;
    bad   = 0;
    rst8 = 1'b1; en8 = 1'b0; rr8 = 1'b0; rdy8 = 1'b0; req8 = '0;
    rst5 = 1'b1; en5 = 1'b0; rr5 = 1'b0; rdy5 = 1'b0; req5 = '0;

    //                rst en rr req    rdy ev idx multi
    vecs8.push_back(mk(1, 1, 0, 8'hFF, 0, 0, 0, 0));  // reset with requests
    vecs8.push_back(mk(1, 1, 0, 8'hFF, 0, 0, 0, 0));
    vecs8.push_back(mk(0, 1, 0, 8'h0A, 1, 1, 3, 1));  // first capture
    vecs8.push_back(mk(0, 1, 0, 8'h01, 1, 1, 0, 0));  // fixed priority
    vecs8.push_back(mk(0, 1, 0, 8'h81, 1, 1, 7, 1));
    vecs8.push_back(mk(0, 1, 0, 8'h30, 1, 1, 5, 1));
    vecs8.push_back(mk(0, 1, 0, 8'h0F, 0, 1, 5, 1));  // stall, req ignored
    vecs8.push_back(mk(0, 1, 0, 8'hF0, 0, 1, 5, 1));
    vecs8.push_back(mk(0, 1, 0, 8'h00, 0, 1, 5, 1));
    vecs8.push_back(mk(0, 1, 0, 8'hFF, 0, 1, 5, 1));
    vecs8.push_back(mk(0, 1, 0, 8'h04, 1, 1, 2, 0));  // release stall
    vecs8.push_back(mk(0, 0, 0, 8'hFF, 1, 0, 2, 0));  // en=0 drains
    vecs8.push_back(mk(0, 0, 0, 8'hFF, 1, 0, 2, 0));
    vecs8.push_back(mk(0, 1, 0, 8'h00, 1, 0, 2, 0));  // req=0, no valid
    vecs8.push_back(mk(1, 1, 0, 8'h00, 1, 0, 0, 0));  // reset ptr
    vecs8.push_back(mk(0, 1, 1, 8'h91, 1, 1, 7, 1));  // round-robin
    vecs8.push_back(mk(0, 1, 1, 8'h91, 1, 1, 4, 1));
    vecs8.push_back(mk(0, 1, 1, 8'h91, 1, 1, 0, 1));
    vecs8.push_back(mk(0, 1, 1, 8'h91, 1, 1, 7, 1));
    vecs8.push_back(mk(0, 1, 1, 8'h91, 1, 1, 4, 1));
    vecs8.push_back(mk(0, 1, 1, 8'h91, 1, 1, 0, 1));
    vecs8.push_back(mk(0, 1, 0, 8'h91, 1, 1, 7, 1));  // fixed updates ptr
    vecs8.push_back(mk(0, 1, 1, 8'h91, 1, 1, 4, 1));  // ptr kept across mode
    vecs8.push_back(mk(0, 1, 1, 8'h10, 1, 1, 4, 0));  // only ptr requests
    vecs8.push_back(mk(0, 1, 1, 8'hFF, 0, 1, 4, 0));  // pending result
    vecs8.push_back(mk(1, 1, 1, 8'hFF, 0, 0, 0, 0));  // reset discards it
    vecs8.push_back(mk(0, 1, 1, 8'h01, 0, 1, 0, 0));
    vecs8.push_back(mk(0, 1, 1, 8'h80, 0, 1, 0, 0));
    vecs8.push_back(mk(0, 1, 1, 8'h00, 1, 0, 0, 0));
    vecs8.push_back(mk(0, 1, 0, 8'h40, 1, 1, 6, 0));

    vecs5.push_back(mk(1, 1, 1, 8'h1F, 0, 0, 0, 0));
    vecs5.push_back(mk(0, 1, 1, 8'h10, 1, 1, 4, 0));  // ptr=0 wraps to 4
    vecs5.push_back(mk(0, 1, 1, 8'h11, 1, 1, 0, 1));
    vecs5.push_back(mk(0, 1, 1, 8'h06, 1, 1, 2, 1));  // from ptr=0 search 4,3,2
    vecs5.push_back(mk(0, 1, 0, 8'h1F, 1, 1, 4, 1));
    vecs5.push_back(mk(0, 0, 1, 8'h1F, 1, 0, 4, 1));
    vecs5.push_back(mk(0, 1, 1, 8'h00, 1, 0, 4, 1));

    for (int k = 0; k < vecs8.size(); k++) begin
      rst8 = vecs8[k].rst; en8 = vecs8[k].en; rr8 = vecs8[k].rr;
      req8 = vecs8[k].req; rdy8 = vecs8[k].rdy;
      @(posedge clk); #1;
      chk("t8_valid", k, 64'(v8),   64'(vecs8[k].ev));
      chk("t8_idx",   k, 64'(idx8), 64'(vecs8[k].eidx));
      chk("t8_multi", k, 64'(m8),   64'(vecs8[k].em));
      chk("t5_idle_valid", k, 64'(v5), 64'd0);
`ifdef PRIO_ENC_ONEHOT_EN
      if (vecs8[k].ev) chk("t8_grant", k, 64'(g8), 64'(8'(1) << vecs8[k].eidx));
      if (vecs8[k].rst) chk("t8_grant_rst", k, 64'(g8), 64'd0);
`endif
    end

    rst8 = 1'b1;
    for (int k = 0; k < vecs5.size(); k++) begin
      rst5 = vecs5[k].rst; en5 = vecs5[k].en; rr5 = vecs5[k].rr;
      req5 = vecs5[k].req[4:0]; rdy5 = vecs5[k].rdy;
      @(posedge clk); #1;
      chk("t5_valid", k, 64'(v5),   64'(vecs5[k].ev));
      chk("t5_idx",   k, 64'(idx5), 64'(vecs5[k].eidx));
      chk("t5_multi", k, 64'(m5),   64'(vecs5[k].em));
`ifdef PRIO_ENC_ONEHOT_EN
      if (vecs5[k].ev) chk("t5_grant", k, 64'(g5), 64'(5'(1) << vecs5[k].eidx));
`endif
    end

    // Random phase: the first cycle resets both instances and the models.
    ms8 = '{v: 1'b0, idx: 0, multi: 1'b0, ptr: 0};
    ms5 = ms8;
    for (int c = 0; c < 600; c++) begin
      rst8 = (c == 0) || ($urandom_range(0, 49) == 0);
      en8  = ($urandom_range(0, 9) != 0);
      rr8  = $urandom_range(0, 1) == 1;
      rdy8 = ($urandom_range(0, 9) < 7);
      req8 = ($urandom_range(0, 4) == 0) ? 8'h00 :
             ($urandom_range(0, 2) == 0) ? (8'(1) << $urandom_range(0, 7)) :
             8'($urandom);
      rst5 = (c == 0) || ($urandom_range(0, 49) == 0);
      en5  = ($urandom_range(0, 9) != 0);
      rr5  = $urandom_range(0, 1) == 1;
      rdy5 = ($urandom_range(0, 9) < 7);
      req5 = ($urandom_range(0, 4) == 0) ? 5'h00 : 5'($urandom);
      nx8 = mnext(ms8, 8, rst8, en8, rr8, 64'(req8), rdy8);
      nx5 = mnext(ms5, 5, rst5, en5, rr5, 64'(req5), rdy5);
      @(posedge clk); #1;
      ms8 = nx8;
      ms5 = nx5;
      chk("r8_valid", c, 64'(v8),   64'(ms8.v));
      chk("r8_idx",   c, 64'(idx8), 64'(ms8.idx));
      chk("r8_multi", c, 64'(m8),   64'(ms8.multi));
      chk("r5_valid", c, 64'(v5),   64'(ms5.v));
      chk("r5_idx",   c, 64'(idx5), 64'(ms5.idx));
      chk("r5_multi", c, 64'(m5),   64'(ms5.multi));
`ifdef PRIO_ENC_ONEHOT_EN
      if (ms8.v) chk("r8_grant", c, 64'(g8), 64'(8'(1) << ms8.idx));
      if (ms5.v) chk("r5_grant", c, 64'(g5), 64'(5'(1) << ms5.idx));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
